// File: rtl/nor_sched_pkg.sv
// Shared definitions for the NOR-cell share scheduler: FSM state encoding
// and the DigitSupply rail codes.
package nor_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2,
        SAMPLE = 2'd3
    } sched_state_e;

    localparam logic [1:0] SUPPLY_ON  = 2'b10;
    localparam logic [1:0] SUPPLY_OFF = 2'b00;

endpackage

// File: rtl/nor_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the
// pointer, wrapping. Produces a one-hot grant, its index and an any-valid flag.
module nor_rr_arbiter
    import nor_sched_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int PTR_W      = 2
) (
    input  logic [REQUESTERS-1:0] req_valid_i,
    input  logic [PTR_W-1:0]      rr_ptr_i,
    output logic [REQUESTERS-1:0] grant_o,
    output logic [PTR_W-1:0]      grant_idx_o,
    output logic                  any_o
);

    // Two ascending passes: first the indices at/after the pointer, then the
    // wrapped-around ones below it. The first hit wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (!any_o && req_valid_i[i] && (PTR_W'(i) >= rr_ptr_i)) begin
                grant_o[i]  = 1'b1;
                grant_idx_o = PTR_W'(i);
                any_o       = 1'b1;
            end
        end
        for (int i = 0; i < REQUESTERS; i++) begin
            if (!any_o && req_valid_i[i]) begin
                grant_o[i]  = 1'b1;
                grant_idx_o = PTR_W'(i);
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nor_share_scheduler.sv
// Time-shares one structural NOR cell among REQUESTERS clients, round-robin.
// Optional feature macro: NOR_SCHED_SUPPLY_GATE_EN -- when defined, DigitSupply
// is powered only while a request is in flight (GRANT/SETTLE/SAMPLE).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no work; operand cleared, waiting for any reqValid
//   GRANT  | reqReady pulse for the pre-picked requester; latch operand
//   SETTLE | operand on the cell, counting down the settle time
//   SAMPLE | capture norOutput; respValid fires next cycle
module nor_share_scheduler
    import nor_sched_pkg::*;
#(
    parameter int REQUESTERS    = 4,
    parameter int INPUT_WIDTH   = 8,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                              clock,
    input  logic                              nReset,
    input  logic [REQUESTERS-1:0]             reqValid,
    input  logic [REQUESTERS*INPUT_WIDTH-1:0] reqData,
    output logic [REQUESTERS-1:0]             reqReady,
    output logic [REQUESTERS-1:0]             respValid,
    output logic                              respData,
    output logic [INPUT_WIDTH-1:0]            norInput,
    output logic [1:0]                        DigitSupply,
    input  logic                              norOutput
);

    localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    sched_state_e             state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [INPUT_WIDTH-1:0]   operand_q, operand_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]         g_idx_q, g_idx_d;
    logic [REQUESTERS-1:0]    req_ready_q, req_ready_d;
    logic [REQUESTERS-1:0]    resp_valid_q, resp_valid_d;
    logic                     resp_data_q, resp_data_d;

    logic [REQUESTERS-1:0]    arb_grant;
    logic [PTR_W-1:0]         arb_idx;
    logic                     arb_any;
    logic [INPUT_WIDTH-1:0]   req_slice [REQUESTERS];

    for (genvar i = 0; i < REQUESTERS; i++) begin : g_slice
        assign req_slice[i] = reqData[i*INPUT_WIDTH +: INPUT_WIDTH];
    end

    nor_rr_arbiter #(
        .REQUESTERS (REQUESTERS),
        .PTR_W      (PTR_W)
    ) u_arb (
        .req_valid_i (reqValid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    // Next-state and datapath updates. The arbiter decision is taken on the
    // way into GRANT so reqReady comes straight from a flop during GRANT.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        operand_d    = operand_q;
        rr_ptr_d     = rr_ptr_q;
        g_idx_d      = g_idx_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        case (state_q)
            IDLE: begin
                operand_d = '0;
                if (arb_any) begin
                    state_d     = GRANT;
                    req_ready_d = arb_grant;
                    g_idx_d     = arb_idx;
                end
            end
            GRANT: begin
                operand_d = req_slice[g_idx_q];
                cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
                rr_ptr_d  = (g_idx_q == PTR_W'(REQUESTERS - 1)) ? '0 : g_idx_q + 1'b1;
                state_d   = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                resp_data_d           = norOutput;
                resp_valid_d[g_idx_q] = 1'b1;
                operand_d             = '0;
                if (arb_any) begin
                    state_d     = GRANT;
                    req_ready_d = arb_grant;
                    g_idx_d     = arb_idx;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, operand, pointer and response registers; reset drops any
    // response still in flight.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            cnt_q        <= '0;
            operand_q    <= '0;
            rr_ptr_q     <= '0;
            g_idx_q      <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            operand_q    <= operand_d;
            rr_ptr_q     <= rr_ptr_d;
            g_idx_q      <= g_idx_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign reqReady  = req_ready_q;
    assign respValid = resp_valid_q;
    assign respData  = resp_data_q;
    assign norInput  = operand_q;

`ifdef NOR_SCHED_SUPPLY_GATE_EN
    logic [1:0] supply_q, supply_d;

    // Power the cell for every non-IDLE cycle; GRANT doubles as power-up.
    always_comb begin
        supply_d = (state_d == IDLE) ? SUPPLY_OFF : SUPPLY_ON;
    end

    // Registered supply rail, off in reset.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            supply_q <= SUPPLY_OFF;
        end else begin
            supply_q <= supply_d;
        end
    end

    assign DigitSupply = supply_q;
`else
    assign DigitSupply = SUPPLY_ON;
`endif

endmodule

// File: tb/tb_nor_share_scheduler.sv
// Directed, table-driven bench for nor_share_scheduler (defaults 4 x 8-bit,
// settle 3). The shared NOR cell is modelled as an ideal combinational NOR.
module tb_nor_share_scheduler;

    localparam int N  = 4;
    localparam int IW = 8;
    localparam int SC = 3;

    logic            clock = 1'b0;
    logic            nReset;
    logic [N-1:0]    reqValid;
    logic [N*IW-1:0] reqData;
    logic [N-1:0]    reqReady;
    logic [N-1:0]    respValid;
    logic            respData;
    logic [IW-1:0]   norInput;
    logic [1:0]      DigitSupply;
    logic            norOutput;

    nor_share_scheduler #(
        .REQUESTERS    (N),
        .INPUT_WIDTH   (IW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clock       (clock),
        .nReset      (nReset),
        .reqValid    (reqValid),
        .reqData     (reqData),
        .reqReady    (reqReady),
        .respValid   (respValid),
        .respData    (respData),
        .norInput    (norInput),
        .DigitSupply (DigitSupply),
        .norOutput   (norOutput)
    );

    assign norOutput = ~|norInput;

    always #5 clock = ~clock;

    typedef struct {
        logic          rst_n;
        logic [N-1:0]  valid;
        logic [N*IW-1:0] data;
        logic [N-1:0]  ready;
        logic [N-1:0]  rvalid;
        logic          rdata;
        logic [IW-1:0] nin;
        logic          busy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input logic rst_n, input logic [N-1:0] v, input logic [N*IW-1:0] d,
                        input logic [N-1:0] rdy, input logic [N-1:0] rv, input logic rd,
                        input logic [IW-1:0] nin, input logic busy);
        vec_t x;
        x.rst_n  = rst_n;
        x.valid  = v;
        x.data   = d;
        x.ready  = rdy;
        x.rvalid = rv;
        x.rdata  = rd;
        x.nin    = nin;
        x.busy   = busy;
        vecs.push_back(x);
    endtask

    function automatic logic [1:0] exp_supply(input logic busy);
        logic [1:0] s;
        s = 2'b10;
`ifdef NOR_SCHED_SUPPLY_GATE_EN
        if (!busy) s = 2'b00;
`endif
        return s;
    endfunction

    task automatic check_vec(input int k, input vec_t x);
        logic [18:0] act, exp;
        logic        rd_act;
        rd_act = (x.rvalid != '0) ? respData : 1'b0;
        act = {reqReady, respValid, rd_act, norInput, DigitSupply};
        exp = {x.ready, x.rvalid, x.rdata, x.nin, exp_supply(x.busy)};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d: got ready=%b rvalid=%b rdata=%b nin=%h sup=%b, want ready=%b rvalid=%b rdata=%b nin=%h sup=%b",
                     k, reqReady, respValid, rd_act, norInput, DigitSupply,
                     x.ready, x.rvalid, x.rdata, x.nin, exp_supply(x.busy));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*IW-1:0] d1, d2, d3, d4;
        logic [IW-1:0]   op3 [N];
        logic            res3 [N];
        int last_cyc, cyc, got;

        nReset   = 1'b0;
        reqValid = '0;
        reqData  = '0;

        // Single request from requester 1, zero operand -> result 1.
        d1 = 32'h5A_00_00_33;
        push(0, 4'b0000, d1, 4'b0000, 4'b0000, 0, 8'h00, 0);
        push(1, 4'b0010, d1, 4'b0010, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b0010, d1, 4'b0000, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b0000, d1, 4'b0000, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b0000, d1, 4'b0000, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b0000, d1, 4'b0000, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b0000, d1, 4'b0000, 4'b0010, 1, 8'h00, 0);
        push(1, 4'b0000, d1, 4'b0000, 4'b0000, 0, 8'h00, 0);

        // Requester 3 with operand 8'h40 -> result 0; operand visible t+1..t+4.
        d2 = 32'h40_11_22_33;
        push(1, 4'b1000, d2, 4'b1000, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b1000, d2, 4'b0000, 4'b0000, 0, 8'h40, 1);
        push(1, 4'b0000, d2, 4'b0000, 4'b0000, 0, 8'h40, 1);
        push(1, 4'b0000, d2, 4'b0000, 4'b0000, 0, 8'h40, 1);
        push(1, 4'b0000, d2, 4'b0000, 4'b0000, 0, 8'h40, 1);
        push(1, 4'b0000, d2, 4'b0000, 4'b1000, 0, 8'h00, 0);

        // Reset, then all four requesting: grant order 0,1,2,3,0 every 5 cycles.
        d3 = 32'h01_00_FF_10;
        op3[0] = 8'h10; op3[1] = 8'hFF; op3[2] = 8'h00; op3[3] = 8'h01;
        res3[0] = 1'b0; res3[1] = 1'b0; res3[2] = 1'b1; res3[3] = 1'b0;
        push(0, 4'b1111, d3, 4'b0000, 4'b0000, 0, 8'h00, 0);
        for (int k = 0; k < 5; k++) begin
            int g, p;
            g = k % N;
            p = (k + N - 1) % N;
            push(1, 4'b1111, d3, 4'(1 << g), (k > 0) ? 4'(1 << p) : 4'b0000,
                 (k > 0) ? res3[p] : 1'b0, 8'h00, 1);
            if (k < 4) begin
                for (int s = 0; s < SC + 1; s++) begin
                    push(1, 4'b1111, d3, 4'b0000, 4'b0000, 0, op3[g], 1);
                end
            end
        end
        push(1, 4'b1111, d3, 4'b0000, 4'b0000, 0, op3[0], 1);
        // Reset in SETTLE: back to IDLE, no respValid ever appears.
        push(0, 4'b1111, d3, 4'b0000, 4'b0000, 0, 8'h00, 0);
        for (int s = 0; s < 6; s++) begin
            push(1, 4'b0000, d3, 4'b0000, 4'b0000, 0, 8'h00, 0);
        end

        // Withdrawal: requester 2 drops while 1 settles; 3 is granted next,
        // then 3 re-requests during its own respValid cycle.
        d4 = 32'h5A_77_00_AA;
        push(1, 4'b1110, d4, 4'b0010, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b1110, d4, 4'b0000, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b1000, d4, 4'b0000, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b1000, d4, 4'b0000, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b1000, d4, 4'b0000, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b1000, d4, 4'b1000, 4'b0010, 1, 8'h00, 1);
        push(1, 4'b1000, d4, 4'b0000, 4'b0000, 0, 8'h5A, 1);
        push(1, 4'b0000, d4, 4'b0000, 4'b0000, 0, 8'h5A, 1);
        push(1, 4'b0000, d4, 4'b0000, 4'b0000, 0, 8'h5A, 1);
        push(1, 4'b0000, d4, 4'b0000, 4'b0000, 0, 8'h5A, 1);
        push(1, 4'b0000, d4, 4'b0000, 4'b1000, 0, 8'h00, 0);
        push(1, 4'b1000, d4, 4'b1000, 4'b0000, 0, 8'h00, 1);
        push(1, 4'b1000, d4, 4'b0000, 4'b0000, 0, 8'h5A, 1);
        push(1, 4'b0000, d4, 4'b0000, 4'b0000, 0, 8'h5A, 1);
        push(1, 4'b0000, d4, 4'b0000, 4'b0000, 0, 8'h5A, 1);
        push(1, 4'b0000, d4, 4'b0000, 4'b0000, 0, 8'h5A, 1);
        push(1, 4'b0000, d4, 4'b0000, 4'b1000, 0, 8'h00, 0);
        push(1, 4'b0000, d4, 4'b0000, 4'b0000, 0, 8'h00, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clock);
            nReset   = vecs[k].rst_n;
            reqValid = vecs[k].valid;
            reqData  = vecs[k].data;
            @(posedge clock);
            #1;
            check_vec(k, vecs[k]);
        end

        // Hand sequence: reqReady pulse spacing and order with all four
        // requesting out of reset, bounded by a cycle budget.
        @(negedge clock);
        nReset   = 1'b0;
        reqValid = 4'b1111;
        reqData  = d3;
        @(negedge clock);
        nReset   = 1'b1;
        last_cyc = 0;
        cyc      = 0;
        got      = 0;
        while (got < 5 && cyc < 60) begin
            @(posedge clock);
            #1;
            cyc++;
            if (reqReady != '0) begin
                n_vec++;
                if (reqReady !== 4'(1 << (got % N))) begin
                    n_err++;
                    $display("FAIL rr_order grant%0d: got reqReady=%b, want %b",
                             got, reqReady, 4'(1 << (got % N)));
                end
                n_vec++;
                if ((got == 0 && cyc != 1) || (got > 0 && (cyc - last_cyc) != SC + 2)) begin
                    n_err++;
                    $display("FAIL rr_spacing grant%0d: got cycle %0d (prev %0d), want %0d",
                             got, cyc, last_cyc, (got == 0) ? 1 : last_cyc + SC + 2);
                end
                last_cyc = cyc;
                got++;
            end
        end
        if (got < 5) begin
            n_vec++;
            n_err++;
            $display("FAIL rr_timeout: got %0d grants, want 5", got);
        end
        @(negedge clock);
        reqValid = '0;
        repeat (8) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
